// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared constants and types for the 640x480@60 VGA timing
//                controller. Holds default porch/sync figures, derived
//                totals, colour-field positions and the timeline bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Datapath widths
    localparam int CNT_W = 10;
    localparam int PIX_W = 12;
    localparam int COL_W = 4;

    // Default 640x480@60 timing (pixel clocks / lines)
    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int DEF_PIPE_DELAY = 1;

    // Derived figures for the default timing
    localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int HS_END   = HS_START + DEF_H_SYNC - 1;
    localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int VS_END   = VS_START + DEF_V_SYNC - 1;

    // Colour fields inside pixel_data
    localparam int B_MSB = 11;
    localparam int B_LSB = 8;
    localparam int G_MSB = 7;
    localparam int G_LSB = 4;
    localparam int R_MSB = 3;
    localparam int R_LSB = 0;

    // Request-timeline bundle carried through the alignment delay
    typedef struct packed {
        logic act;
        logic hs_n;
        logic vs_n;
    } timeline_t;

    // Idle timeline: blanked, both syncs deasserted
    localparam timeline_t TL_IDLE = '{act: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

    // Force the colour to black outside the visible area
    function automatic logic [PIX_W-1:0] blank_pixel(input logic act,
                                                     input logic [PIX_W-1:0] pix);
        return act ? pix : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_ctrl_if
//  Description : Renderer/DAC-side signal bundle of the VGA timing
//                controller. master = controller, slave = renderer/board.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_ctrl_if;
    import vga_timing_pkg::*;

    logic [PIX_W-1:0] pixel_data;
    logic [CNT_W-1:0] x_pos;
    logic [CNT_W-1:0] y_pos;
    logic             frame_start;
    logic [COL_W-1:0] vga_r;
    logic [COL_W-1:0] vga_g;
    logic [COL_W-1:0] vga_b;
    logic             vga_hs;
    logic             vga_vs;

    modport master (
        input  pixel_data,
        output x_pos, y_pos, frame_start,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs
    );

    modport slave (
        output pixel_data,
        input  x_pos, y_pos, frame_start,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs
    );

endinterface
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : vga_delay_line
//  Description : WIDTH-bit, DEPTH-stage shift register with a synchronous
//                reset to a caller-supplied value. DEPTH=0 is a wire.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] rst_val_i,
    input  wire logic [WIDTH-1:0] d_i,
    output logic      [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            // No stages: clock, reset and reset value are not needed
            logic unused_bypass;
            assign unused_bypass = ^{clk, rst, rst_val_i};
            assign q_o = d_i;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            // Shift one stage per clock; reset loads every stage with rst_val_i
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= rst_val_i;
                    end
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_ctrl
//  Description : 640x480@60 VGA timing generator. Issues pixel requests
//                (x_pos/y_pos), delays sync/blank by the renderer latency
//                and registers colour and syncs onto the DAC pins.
//                PIPE_DELAY legal range is 0..4.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
    input  wire logic          vga_clk,
    input  wire logic          vga_rst,
    vga_timing_ctrl_if.master  vga
);

    // Sized timing constants so every compare is a plain CNT_W-bit unsigned compare
    localparam logic [CNT_W-1:0] C_H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] C_V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] C_H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] C_V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] C_HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] C_HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] C_VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] C_VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             w_h_act, w_v_act;
    timeline_t        w_tl_req;
    timeline_t        w_tl_dly;
    logic [PIX_W-1:0] w_pix;
    logic [COL_W-1:0] r_d, g_d, b_d, r_q, g_q, b_q;
    logic             hs_d, vs_d, hs_q, vs_q;

    // Raster counters: h wraps every line, v advances only on the h wrap
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == C_H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == C_V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    // Counter registers; reset restarts the raster at (0,0)
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Request timeline decoded straight from the counters
    always_comb begin
        w_h_act       = (h_cnt_q < C_H_ACT);
        w_v_act       = (v_cnt_q < C_V_ACT);
        w_tl_req.act  = w_h_act && w_v_act;
        w_tl_req.hs_n = !((h_cnt_q >= C_HS_START) && (h_cnt_q <= C_HS_END));
        w_tl_req.vs_n = !((v_cnt_q >= C_VS_START) && (v_cnt_q <= C_VS_END));
    end

    assign vga.x_pos       = w_h_act ? h_cnt_q : '0;
    assign vga.y_pos       = w_v_act ? v_cnt_q : '0;
    assign vga.frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);

    // Hold act/syncs back by the renderer latency so they meet pixel_data
    vga_delay_line #(
        .WIDTH ($bits(timeline_t)),
        .DEPTH (PIPE_DELAY)
    ) u_align (
        .clk       (vga_clk),
        .rst       (vga_rst),
        .rst_val_i (TL_IDLE),
        .d_i       (w_tl_req),
        .q_o       (w_tl_dly)
    );

    // Blank and split the returned colour, pass delayed syncs through
    always_comb begin
        w_pix = blank_pixel(w_tl_dly.act, vga.pixel_data);
        r_d   = w_pix[R_MSB:R_LSB];
        g_d   = w_pix[G_MSB:G_LSB];
        b_d   = w_pix[B_MSB:B_LSB];
        hs_d  = w_tl_dly.hs_n;
        vs_d  = w_tl_dly.vs_n;
    end

    // Pin registers; reset drives black with both syncs deasserted
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else begin
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
        end
    end

    assign vga.vga_r  = r_q;
    assign vga.vga_g  = g_q;
    assign vga.vga_b  = b_q;
    assign vga.vga_hs = hs_q;
    assign vga.vga_vs = vs_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_ctrl
//  Description : Testbench for vga_timing_ctrl. Instance A uses default
//                640x480 timing with PIPE_DELAY=1; instance B uses a tiny
//                16x12 raster with PIPE_DELAY=3 so whole frames fit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_ctrl;

    typedef struct {
        int         tag;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic white_b = 1'b0;
    int   tick = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tick <= tick + 1;

    vga_timing_ctrl_if ifa ();
    vga_timing_ctrl_if ifb ();

    // Renderer models: A has 1 register stage, B has 3
    logic [11:0] pix_a;
    logic [9:0]  rb1, rb2, rb3;
    always @(posedge clk) begin
        pix_a <= {2'h0, ifa.x_pos};
        rb1   <= ifb.x_pos;
        rb2   <= rb1;
        rb3   <= rb2;
    end
    assign ifa.pixel_data = pix_a;
    assign ifb.pixel_data = white_b ? 12'hFFF : {2'h0, rb3};

    vga_timing_ctrl #(
        .PIPE_DELAY (1)
    ) u_dut_a (
        .vga_clk (clk),
        .vga_rst (rst_a),
        .vga     (ifa)
    );

    vga_timing_ctrl #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6), .V_FP (2), .V_SYNC (2), .V_BP (2),
        .PIPE_DELAY (3)
    ) u_dut_b (
        .vga_clk (clk),
        .vga_rst (rst_b),
        .vga     (ifb)
    );

    // Expected state of cycle c after reset release, from closed-form raster position
    function automatic exp_t model(input int c, input int pd,
                                   input int ha, input int hfp, input int hsw, input int hbp,
                                   input int va, input int vfp, input int vsw, input int vbp,
                                   input logic white);
        exp_t e;
        int ht, vt, h, v, k, hk, vk;
        logic [11:0] pix;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        h  = c % ht;
        v  = (c / ht) % vt;
        e.tag = 0;
        e.x  = (h < ha) ? 10'(h) : 10'd0;
        e.y  = (v < va) ? 10'(v) : 10'd0;
        e.fs = (h == 0) && (v == 0);
        e.r = 4'h0; e.g = 4'h0; e.b = 4'h0; e.hs = 1'b1; e.vs = 1'b1;
        k = c - pd - 1;
        if (k >= 0) begin
            hk = k % ht;
            vk = (k / ht) % vt;
            e.hs = !((hk >= ha + hfp) && (hk < ha + hfp + hsw));
            e.vs = !((vk >= va + vfp) && (vk < va + vfp + vsw));
            if ((hk < ha) && (vk < va)) begin
                pix = white ? 12'hFFF : 12'(hk);
                e.b = pix[11:8];
                e.g = pix[7:4];
                e.r = pix[3:0];
            end
        end
        return e;
    endfunction

    task automatic check_pins(input string nm, input exp_t e,
                              input logic [9:0] x, input logic [9:0] y, input logic fs,
                              input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                              input logic hs, input logic vs);
        n_checks++;
        if ({x, y, fs, r, g, b, hs, vs} !== {e.x, e.y, e.fs, e.r, e.g, e.b, e.hs, e.vs}) begin
            n_errors++;
            $display("FAIL %s tick=%0d: got x=%0d y=%0d fs=%b bgr=%h%h%h hs=%b vs=%b, expected x=%0d y=%0d fs=%b bgr=%h%h%h hs=%b vs=%b",
                     nm, tick, x, y, fs, b, g, r, hs, vs, e.x, e.y, e.fs, e.b, e.g, e.r, e.hs, e.vs);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    // Scoreboard producers: at each negedge queue what the next cycle must show
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t pa, pb, ea, eb;
    int   mc_a = -1000;
    int   mc_b = -1000;

    always @(negedge clk) begin
        mc_a = rst_a ? 0 : mc_a + 1;
        if (mc_a >= 0) begin
            pa = model(mc_a, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
            pa.tag = tick + 1;
            q_a.push_back(pa);
        end
    end

    always @(negedge clk) begin
        mc_b = rst_b ? 0 : mc_b + 1;
        if (mc_b >= 0) begin
            pb = model(mc_b, 3, 8, 2, 3, 3, 6, 2, 2, 2, white_b);
            pb.tag = tick + 1;
            q_b.push_back(pb);
        end
    end

    // Scoreboard monitors: compare DUT outputs against the entry tagged for this cycle
    always @(negedge clk) begin
        if (q_a.size() > 0 && q_a[0].tag == tick) begin
            ea = q_a.pop_front();
            check_pins("sb_a", ea, ifa.x_pos, ifa.y_pos, ifa.frame_start,
                       ifa.vga_r, ifa.vga_g, ifa.vga_b, ifa.vga_hs, ifa.vga_vs);
        end
    end

    always @(negedge clk) begin
        if (q_b.size() > 0 && q_b[0].tag == tick) begin
            eb = q_b.pop_front();
            check_pins("sb_b", eb, ifb.x_pos, ifb.y_pos, ifb.frame_start,
                       ifb.vga_r, ifb.vga_g, ifb.vga_b, ifb.vga_hs, ifb.vga_vs);
        end
    end

    function automatic logic sig(input int sel);
        case (sel)
            0:       return ifa.vga_hs == 1'b0;
            1:       return ifa.vga_hs == 1'b1;
            2:       return ifb.vga_vs == 1'b0;
            3:       return ifb.vga_vs == 1'b1;
            4:       return ifb.frame_start == 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_cyc(input int base, input int c);
        while (tick - base < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance cycle by cycle until the selected condition holds; -1 if it never does
    task automatic seek(input int base, input int lim, input int sel, output int at);
        at = -1;
        for (int n = 0; n < lim; n++) begin
            @(posedge clk);
            #1;
            if (sig(sel)) begin
                at = tick - base;
                break;
            end
        end
    endtask

    initial begin
        fork
            begin : thr_a
                int base_a, at_a;
                repeat (3) @(posedge clk);
                #1;
                base_a = tick;
                rst_a  = 1'b0;
                chk("a_reset_pins", {ifa.vga_hs, ifa.vga_vs, ifa.vga_b, ifa.vga_g, ifa.vga_r}, 32'h3000);
                chk("a_reset_req", {ifa.frame_start, ifa.x_pos, ifa.y_pos}, 32'h0010_0000);
                wait_cyc(base_a, 7);
                chk("a_align_h5", {ifa.vga_b, ifa.vga_g, ifa.vga_r}, 32'h005);
                wait_cyc(base_a, 641);
                chk("a_align_h639", {ifa.vga_b, ifa.vga_g, ifa.vga_r}, 32'h27F);
                wait_cyc(base_a, 642);
                chk("a_blank_h640", {ifa.vga_b, ifa.vga_g, ifa.vga_r}, 32'h000);
                seek(base_a, 200, 0, at_a);
                chk("a_hs_fall", at_a, 658);
                seek(base_a, 200, 1, at_a);
                chk("a_hs_rise", at_a, 754);
                seek(base_a, 800, 0, at_a);
                chk("a_hs_period", at_a, 1458);
                wait_cyc(base_a, 1607);
                chk("a_align_l1_h805", {ifa.vga_b, ifa.vga_g, ifa.vga_r}, 32'h005);
                chk("a_y_line2", ifa.y_pos, 32'd2);
                wait_cyc(base_a, 2400);
            end
            begin : thr_b
                int base_b, at_b;
                repeat (3) @(posedge clk);
                #1;
                base_b = tick;
                rst_b  = 1'b0;
                chk("b_reset_pins", {ifb.vga_hs, ifb.vga_vs, ifb.vga_b, ifb.vga_g, ifb.vga_r, ifb.frame_start}, 32'h6001);
                wait_cyc(base_b, 9);
                chk("b_align_h5", {ifb.vga_b, ifb.vga_g, ifb.vga_r}, 32'h005);
                wait_cyc(base_b, 11);
                chk("b_align_h7", {ifb.vga_b, ifb.vga_g, ifb.vga_r}, 32'h007);
                wait_cyc(base_b, 12);
                chk("b_blank_h8", {ifb.vga_b, ifb.vga_g, ifb.vga_r}, 32'h000);
                seek(base_b, 300, 2, at_b);
                chk("b_vs_fall", at_b, 132);
                seek(base_b, 100, 3, at_b);
                chk("b_vs_rise", at_b, 164);
                seek(base_b, 100, 4, at_b);
                chk("b_frame_period", at_b, 192);
                white_b = 1'b1;
                wait_cyc(base_b, 215);
                chk("b_white_l1_h3", {ifb.vga_b, ifb.vga_g, ifb.vga_r}, 32'hFFF);
                wait_cyc(base_b, 221);
                chk("b_white_l1_h9", {ifb.vga_b, ifb.vga_g, ifb.vga_r}, 32'h000);
                wait_cyc(base_b, 278);
                chk("b_white_l5_h2", {ifb.vga_b, ifb.vga_g, ifb.vga_r}, 32'hFFF);
                wait_cyc(base_b, 294);
                chk("b_white_l6_h2", {ifb.vga_b, ifb.vga_g, ifb.vga_r}, 32'h000);
                wait_cyc(base_b, 342);
                chk("b_vs_low_l9", ifb.vga_vs, 32'd0);
                rst_b = 1'b1;
                @(posedge clk);
                #1;
                chk("b_midrst_pins", {ifb.vga_hs, ifb.vga_vs, ifb.vga_b, ifb.vga_g, ifb.vga_r}, 32'h3000);
                chk("b_midrst_req", {ifb.frame_start, ifb.x_pos, ifb.y_pos}, 32'h0010_0000);
                rst_b  = 1'b0;
                base_b = tick;
                seek(base_b, 300, 2, at_b);
                chk("b_vs_fall_after_rst", at_b, 132);
                seek(base_b, 100, 4, at_b);
                chk("b_frame_after_rst", at_b, 192);
                wait_cyc(base_b, 250);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Generates 640x480@60 Hz VGA timing from the 25 MHz pixel clock.
- Drives the pixel coordinates (x_pos, y_pos) consumed by the page renderers (page_game etc.).
- Accepts their registered 12-bit pixel_data and re-aligns it with delayed sync/blank, driving the physical VGA pins.
- Sits between the renderer mux and the board DAC.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIPE_DELAY, 1, renderer latency in clocks from x_pos/y_pos to valid pixel_data; legal range 0..4

Ports:
- vga_clk  in  1  pixel clock, 25 MHz; all logic on rising edge
- vga_rst  in  1  synchronous, active-high reset
- pixel_data  in  12  renderer colour; [11:8] blue, [7:4] green, [3:0] red
- x_pos  out  10  requested column, 0..639
- y_pos  out  10  requested row, 0..479
- frame_start  out  1  one-cycle pulse at request coordinate (0,0)
- vga_r  out  4  red to DAC
- vga_g  out  4  green to DAC
- vga_b  out  4  blue to DAC
- vga_hs  out  1  horizontal sync, active-low
- vga_vs  out  1  vertical sync, active-low

Behaviour:
- Clock and reset: one clock, vga_clk. Reset is synchronous and active-high on vga_rst, sampled on the rising edge of vga_clk.
- Counters:
  - h_cnt counts 0..H_TOTAL-1, where H_TOTAL = 800.
  - v_cnt counts 0..V_TOTAL-1, where V_TOTAL = 525.
  - h_cnt wraps to 0 after 799. v_cnt increments only on that wrap and wraps to 0 after 524.
- Request timeline (combinational from the counters):
  - act = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - x_pos = h_cnt when h_cnt < H_ACTIVE, else 0.
  - y_pos = v_cnt when v_cnt < V_ACTIVE, else 0.
  - frame_start = (h_cnt == 0 && v_cnt == 0).
- Sync decode on the request timeline:
  - hs_n = 0 iff 656 <= h_cnt <= 751.
  - vs_n = 0 iff 490 <= v_cnt <= 491.
  - Bounds come from the parameters, e.g. H_ACTIVE+H_FP .. H_ACTIVE+H_FP+H_SYNC-1.
- Alignment:
  - {act, hs_n, vs_n} pass through a PIPE_DELAY-stage shift register.
  - Output registers then sample the delayed values together with pixel_data.
  - Pin state at cycle t therefore reflects counters at cycle t-(PIPE_DELAY+1), combined with the pixel_data sampled at cycle t-1.
  - PIPE_DELAY=0 degenerates to the output register only.
- Blanking: when the delayed act is 0, vga_r/g/b = 0 regardless of pixel_data. Otherwise vga_b = pixel_data[11:8], vga_g = pixel_data[7:4], vga_r = pixel_data[3:0].
- Reset values:
  - h_cnt = 0, v_cnt = 0.
  - All delay stages cleared to act=0, hs_n=1, vs_n=1.
  - vga_r/g/b = 0, vga_hs = 1, vga_vs = 1.
  - x_pos = 0, y_pos = 0, frame_start = 1 (counters at 0,0).
- Reset mid-frame: takes effect at the next edge. Counters restart at (0,0), pins go blank with syncs deasserted, and the pipeline is flushed; no partial sync pulse is extended.
- No state machine beyond the counters. No pixel_data handshake: renderers must meet PIPE_DELAY exactly.
- Widths: counters 10 bits. Comparisons are unsigned, and no arithmetic overflow is possible at the default parameters.

Decomposition:
- Package vga_timing_pkg holds:
  - the default timing constants and derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END;
  - the colour-field bit positions (B[11:8], G[7:4], R[3:0]).
- One sub-module, vga_delay_line: a parameterised width/depth shift register with a synchronous reset value input, used for the {act, hs_n, vs_n} alignment.

Test Plan:
- Reset: hold vga_rst 3 cycles, release → vga_hs=1, vga_vs=1, rgb=0, frame_start=1 in first cycle, x_pos=0, y_pos=0.
- Horizontal timing: from reset release, PIPE_DELAY=1 → vga_hs falls 658 cycles later (656+2), stays low 96 cycles, and the period is 800 cycles.
- Vertical timing: vga_vs low for exactly 1600 cycles, starting when line 490 reaches the pins. frame_start recurs every 420000 cycles.
- Alignment: bench renderer registers pixel_data = {2'h0, x_pos} one cycle after x_pos. On line 0, the pin at the cycle reflecting h_cnt=5 shows vga_b=0, vga_g=0, vga_r=5. At h_cnt=639 it shows vga_g=7, vga_r=15. Repeat with PIPE_DELAY=3 and a 3-stage renderer model.
- Blanking: pixel_data held 12'hFFF → rgb=0 for every pin cycle reflecting h_cnt 640..799 or v_cnt 480..524, and rgb=F/F/F elsewhere.
- Mid-frame reset: assert vga_rst during vsync on line 491 → next cycle vga_vs=1 and rgb=0. After release, the full 800x525 sequence restarts from (0,0).
